// File: rtl/l1_out_bank_reader.sv
// l1_out_bank_reader: streams the four row-interleaved layer-1 output banks
// back out as an ordered pixel stream for the next layer.
// Ports: clk, rst (sync, active-high); start + cfg_out_w/cfg_out_h/cfg_blocks
// begin a frame; busy/done report progress; rd_en0..3/rd_addr0..3 issue bank
// reads and rd_data0..3 return one cycle later; m_valid/m_ready/m_data with
// m_row/m_col/m_blk/m_last form the output beat stream.
module l1_out_bank_reader #(
  parameter int UNIT_NUM   = 16,
  parameter int OUT_BITS   = 8,
  parameter int OUT_W_MAX  = 112,
  parameter int OUT_H_MAX  = 112,
  parameter int BLOCKS_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [7:0] cfg_out_w,
  input  logic [7:0] cfg_out_h,
  input  logic [2:0] cfg_blocks,
  output logic busy,
  output logic done,
  output logic rd_en0,
  output logic rd_en1,
  output logic rd_en2,
  output logic rd_en3,
  output logic [15:0] rd_addr0,
  output logic [15:0] rd_addr1,
  output logic [15:0] rd_addr2,
  output logic [15:0] rd_addr3,
  input  logic [UNIT_NUM*OUT_BITS-1:0] rd_data0,
  input  logic [UNIT_NUM*OUT_BITS-1:0] rd_data1,
  input  logic [UNIT_NUM*OUT_BITS-1:0] rd_data2,
  input  logic [UNIT_NUM*OUT_BITS-1:0] rd_data3,
  output logic m_valid,
  input  logic m_ready,
  output logic [UNIT_NUM*OUT_BITS-1:0] m_data,
  output logic [$clog2(OUT_H_MAX)-1:0] m_row,
  output logic [$clog2(OUT_W_MAX)-1:0] m_col,
  output logic [$clog2(BLOCKS_MAX)-1:0] m_blk,
  output logic m_last
);

  localparam int DW = UNIT_NUM * OUT_BITS;
  localparam int RW = $clog2(OUT_H_MAX);
  localparam int CW = $clog2(OUT_W_MAX);
  localparam int BW = $clog2(BLOCKS_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state;
  logic [7:0] w_q;
  logic [7:0] h_q;
  logic [2:0] b_q;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [BW-1:0] blk;

  logic rd_v;
  logic [1:0] bank_d;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_d;
  logic [BW-1:0] blk_d;
  logic last_d;

  logic [DW-1:0] f_data [4];
  logic [RW-1:0] f_row [4];
  logic [CW-1:0] f_col [4];
  logic [BW-1:0] f_blk [4];
  logic f_last [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] cnt;

  logic pop;
  logic push;
  logic issue;
  logic [2:0] resv;
  logic [2:0] cnt_nx;
  logic last_blk;
  logic last_col;
  logic last_row;
  logic fin;
  logic zero_cfg;
  logic [31:0] addr32;
  logic [DW-1:0] sel;

  assign m_valid = (cnt != 3'd0);
  assign pop = m_valid & m_ready;
  assign push = rd_v;
  // Credits: reads in flight plus buffered beats, net of this cycle's pop.
  assign resv = 3'(rd_v) + cnt - 3'(pop);
  assign cnt_nx = cnt + 3'(push) - 3'(pop);
  assign issue = (state == RUN) && (resv < 3'd4);

  assign last_blk = (3'(blk) == b_q - 3'd1);
  assign last_col = (8'(col) == w_q - 8'd1);
  assign last_row = (8'(row) == h_q - 8'd1);
  assign fin = last_blk & last_col & last_row;
  assign zero_cfg = (cfg_out_w == 8'd0) || (cfg_out_h == 8'd0)
                 || (cfg_blocks == 3'd0);

  assign addr32 = (32'(row) * 32'(w_q) + 32'(col)) * 32'(b_q)
                + 32'(blk);

  assign rd_en0 = issue && (row[1:0] == 2'd0);
  assign rd_en1 = issue && (row[1:0] == 2'd1);
  assign rd_en2 = issue && (row[1:0] == 2'd2);
  assign rd_en3 = issue && (row[1:0] == 2'd3);
  assign rd_addr0 = addr32[15:0];
  assign rd_addr1 = addr32[15:0];
  assign rd_addr2 = addr32[15:0];
  assign rd_addr3 = addr32[15:0];

  assign busy = (state != IDLE);

  always_comb begin
    sel = rd_data0;
    case (bank_d)
      2'd1: sel = rd_data1;
      2'd2: sel = rd_data2;
      2'd3: sel = rd_data3;
      default: sel = rd_data0;
    endcase
  end

  // Head of the buffer is gated so idle outputs read as zero.
  assign m_data = m_valid ? f_data[rp] : '0;
  assign m_row = m_valid ? f_row[rp] : '0;
  assign m_col = m_valid ? f_col[rp] : '0;
  assign m_blk = m_valid ? f_blk[rp] : '0;
  assign m_last = m_valid ? f_last[rp] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      w_q <= '0;
      h_q <= '0;
      b_q <= '0;
      row <= '0;
      col <= '0;
      blk <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            w_q <= cfg_out_w;
            h_q <= cfg_out_h;
            b_q <= cfg_blocks;
            row <= '0;
            col <= '0;
            blk <= '0;
            if (zero_cfg) done <= 1'b1;
            else state <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (fin) begin
              state <= DRAIN;
            end else if (last_blk) begin
              blk <= '0;
              if (last_col) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              blk <= blk + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!rd_v && cnt_nx == 3'd0) begin
            done <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags travel with each read so returning data lands with its coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v <= 1'b0;
      bank_d <= '0;
      row_d <= '0;
      col_d <= '0;
      blk_d <= '0;
      last_d <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      rd_v <= issue;
      bank_d <= row[1:0];
      row_d <= row;
      col_d <= col;
      blk_d <= blk;
      last_d <= fin;
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wp] <= sel;
      f_row[wp] <= row_d;
      f_col[wp] <= col_d;
      f_blk[wp] <= blk_d;
      f_last[wp] <= last_d;
    end
  end

endmodule

// File: tb/tb_l1_out_bank_reader.sv
// tb_l1_out_bank_reader: directed frames against a queue-based model of the
// expected read sequence and beat stream, plus literal timing expectations.
module tb_l1_out_bank_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] cfg_out_w = '0;
  logic [7:0] cfg_out_h = '0;
  logic [2:0] cfg_blocks = '0;
  logic busy, done;
  logic rd_en0, rd_en1, rd_en2, rd_en3;
  logic [15:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [127:0] rd_data0 = '0;
  logic [127:0] rd_data1 = '0;
  logic [127:0] rd_data2 = '0;
  logic [127:0] rd_data3 = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [127:0] m_data;
  logic [6:0] m_row, m_col;
  logic [1:0] m_blk;
  logic m_last;

  l1_out_bank_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h),
    .cfg_blocks(cfg_blocks), .busy(busy), .done(done),
    .rd_en0(rd_en0), .rd_en1(rd_en1),
    .rd_en2(rd_en2), .rd_en3(rd_en3),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_data2(rd_data2), .rd_data3(rd_data3),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_blk(m_blk), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bank;
    int addr;
    int rel;
  } rd_t;

  typedef struct {
    int row;
    int col;
    int blk;
    logic [127:0] data;
    bit last;
  } beat_t;

  rd_t exp_reads[$];
  rd_t rd_log[$];
  beat_t exp_beats[$];
  beat_t beat_log[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int c0 = 0;
  bit mon_en = 1'b0;
  int issued, popped, done_cnt, done_cyc, last_cyc, first_rd, first_v;
  bit hold = 1'b0;
  beat_t held;

  function automatic logic [127:0] f(input int k, input int a);
    return {32'(k) * 32'h01000193 ^ 32'(a), 32'(a) * 32'h9E3779B1,
            ~32'(a), 32'(k * 256 + a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= f(0, int'(rd_addr0));
    if (rd_en1) rd_data1 <= f(1, int'(rd_addr1));
    if (rd_en2) rd_data2 <= f(2, int'(rd_addr2));
    if (rd_en3) rd_data3 <= f(3, int'(rd_addr3));
  end

  always @(negedge clk) begin
    int n, b, rel;
    rd_t r, er;
    beat_t a, e;
    if (mon_en) begin
      rel = cyc - c0 + 1;
      n = int'(rd_en0) + int'(rd_en1) + int'(rd_en2) + int'(rd_en3);
      chk("rd_onehot", 128'(n <= 1), 128'(1));
      if (n > 0) begin
        b = rd_en1 ? 1 : rd_en2 ? 2 : rd_en3 ? 3 : 0;
        chk("addr_same", 128'(rd_addr0 == rd_addr1 &&
            rd_addr0 == rd_addr2 && rd_addr0 == rd_addr3), 128'(1));
        r.bank = b;
        r.addr = int'(rd_addr0);
        r.rel = rel;
        rd_log.push_back(r);
        issued++;
        if (first_rd < 0) first_rd = rel;
        if (exp_reads.size() == 0) begin
          chk("rd_extra", 128'(1), 128'(0));
        end else begin
          er = exp_reads.pop_front();
          chk("rd_bank", 128'(b), 128'(er.bank));
          chk("rd_addr", 128'(rd_addr0), 128'(er.addr));
        end
      end
      if (m_valid && first_v < 0) first_v = rel;
      if (hold) begin
        chk("hold_valid", 128'(m_valid), 128'(1));
        chk("hold_data", m_data, held.data);
        chk("hold_tag", {m_row, m_col, m_blk, m_last},
            {7'(held.row), 7'(held.col), 2'(held.blk), held.last});
      end
      if (m_valid && m_ready) begin
        popped++;
        a.row = int'(m_row);
        a.col = int'(m_col);
        a.blk = int'(m_blk);
        a.data = m_data;
        a.last = m_last;
        beat_log.push_back(a);
        if (m_last) last_cyc = rel;
        if (exp_beats.size() == 0) begin
          chk("beat_extra", 128'(1), 128'(0));
        end else begin
          e = exp_beats.pop_front();
          chk("beat_row", 128'(m_row), 128'(e.row));
          chk("beat_col", 128'(m_col), 128'(e.col));
          chk("beat_blk", 128'(m_blk), 128'(e.blk));
          chk("beat_data", m_data, e.data);
          chk("beat_last", 128'(m_last), 128'(e.last));
        end
      end
      chk("credit", 128'(issued - popped <= 4), 128'(1));
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
      hold = m_valid && !m_ready;
      held.row = int'(m_row);
      held.col = int'(m_col);
      held.blk = int'(m_blk);
      held.data = m_data;
      held.last = m_last;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, rd_en0, rd_en1, rd_en2, rd_en3,
        m_valid, m_last}, 128'(0));
    chk({tag, "_addr"}, {rd_addr0, rd_addr1, rd_addr2, rd_addr3},
        128'(0));
    chk({tag, "_data"}, m_data, 128'(0));
    chk({tag, "_tag"}, {m_row, m_col, m_blk}, 128'(0));
  endtask

  task automatic run_frame(input int w, input int h, input int b,
                           input int slo, input int shi, input int ms,
                           input bit tchk);
    int n, rel, k, a;
    beat_t e;
    rd_t r;
    exp_beats.delete();
    exp_reads.delete();
    rd_log.delete();
    beat_log.delete();
    issued = 0;
    popped = 0;
    done_cnt = 0;
    done_cyc = -1;
    last_cyc = -1;
    first_rd = -1;
    first_v = -1;
    hold = 1'b0;
    for (int ro = 0; ro < h; ro++)
      for (int co = 0; co < w; co++)
        for (int bl = 0; bl < b; bl++) begin
          a = ((ro * w + co) * b + bl) & 16'hffff;
          r.bank = ro % 4;
          r.addr = a;
          r.rel = 0;
          exp_reads.push_back(r);
          e.row = ro;
          e.col = co;
          e.blk = bl;
          e.data = f(ro % 4, a);
          e.last = (ro == h - 1 && co == w - 1 && bl == b - 1);
          exp_beats.push_back(e);
        end
    n = w * h * b;
    cfg_out_w = 8'(w);
    cfg_out_h = 8'(h);
    cfg_blocks = 3'(b);
    start = 1'b1;
    m_ready = !(1 >= slo && 1 <= shi);
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    mon_en = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
      rel = cyc - c0 + 1;
      m_ready = !(rel >= slo && rel <= shi);
      if (rel == ms) begin
        start = 1'b1;
        cfg_out_w = 8'd1;
        cfg_out_h = 8'd1;
        cfg_blocks = 3'd1;
      end else begin
        start = 1'b0;
      end
    end
    if (done_cnt == 0) chk("timeout", 128'(0), 128'(1));
    m_ready = 1'b1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("done_count", 128'(done_cnt), 128'(1));
    chk("beats_left", 128'(exp_beats.size()), 128'(0));
    chk("reads_left", 128'(exp_reads.size()), 128'(0));
    if (tchk) begin
      chk("done_cyc", 128'(done_cyc), 128'(n + 3));
      if (n > 0) chk("last_cyc", 128'(last_cyc), 128'(n + 2));
    end
  endtask

  int cnt10;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2x4x1: bank per row, addresses in raster order
    run_frame(2, 4, 1, 0, 0, -1, 1'b1);
    chk("t1_first_rd", 128'(first_rd), 128'(1));
    chk("t1_first_v", 128'(first_v), 128'(3));
    chk("t1_last", 128'(last_cyc), 128'(10));
    chk("t1_done", 128'(done_cyc), 128'(11));
    chk("t1_nrd", 128'(rd_log.size()), 128'(8));
    for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
      chk("t1_bank", 128'(rd_log[i].bank), 128'(i / 2));
      chk("t1_addr", 128'(rd_log[i].addr), 128'(i));
    end

    // 3x1x3: blocks innermost
    run_frame(3, 1, 3, 0, 0, -1, 1'b1);
    for (int i = 0; i < 9 && i < beat_log.size(); i++) begin
      chk("t2_blk", 128'(beat_log[i].blk), 128'(i % 3));
      chk("t2_data", beat_log[i].data, f(0, i));
      chk("t2_addr", 128'(rd_log[i].addr), 128'(i));
    end

    // 2x5x2: row 4 wraps to bank 0
    run_frame(2, 5, 2, 0, 0, -1, 1'b1);
    chk("t3_nrd", 128'(rd_log.size()), 128'(20));
    for (int i = 16; i < 20 && i < rd_log.size(); i++) begin
      chk("t3_bank", 128'(rd_log[i].bank), 128'(0));
      chk("t3_addr", 128'(rd_log[i].addr), 128'(i));
    end

    // backpressure in cycles 3..10
    run_frame(2, 4, 1, 3, 10, -1, 1'b0);
    cnt10 = 0;
    foreach (rd_log[i]) if (rd_log[i].rel <= 10) cnt10++;
    chk("t4_stall_rds", 128'(cnt10), 128'(4));
    chk("t4_beats", 128'(beat_log.size()), 128'(8));

    // zero height
    run_frame(2, 0, 1, 0, 0, -1, 1'b0);
    chk("t5_done", 128'(done_cyc), 128'(1));
    chk("t5_nrd", 128'(rd_log.size()), 128'(0));

    // start pulse during RUN is ignored
    run_frame(3, 2, 2, 0, 0, 3, 1'b1);
    chk("t6_done", 128'(done_cyc), 128'(15));

    // reset in cycle 5 of a 16-beat frame
    cfg_out_w = 8'd4;
    cfg_out_h = 8'd4;
    cfg_blocks = 3'd1;
    start = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t7_busy_pre", 128'(busy), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("t7_rst");
    @(negedge clk);
    chk_zero("t7_rst2");
    run_frame(2, 2, 2, 0, 0, -1, 1'b1);
    if (rd_log.size() > 0) begin
      chk("t7_addr0", 128'(rd_log[0].addr), 128'(0));
      chk("t7_bank0", 128'(rd_log[0].bank), 128'(0));
    end else begin
      chk("t7_no_rd", 128'(0), 128'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
